// File: rtl/cmd_assembler_if.sv
// Byte-stream input and engine-dispatch bus for cmd_assembler.
// slave is the assembler side; master is the byte source / engine side.
interface cmd_assembler_if #(
    parameter int unsigned NUM_ENGINES = 5,
    parameter int unsigned MAX_BYTES   = 16
);
    logic                     i2c_rts;
    logic                     i2c_rtr;
    logic [7:0]               i2c_in_data;
    logic [NUM_ENGINES-1:0]   engine_out_rts;
    logic [NUM_ENGINES-1:0]   engine_in_rtr;
    logic [MAX_BYTES*8-1:0]   bcast_out_data;
    logic [7:0]               bcast_len;
    logic                     busy;
    logic                     err_opcode;
    logic                     err_timeout;

    modport slave (
        input  i2c_rts, i2c_in_data, engine_in_rtr,
        output i2c_rtr, engine_out_rts, bcast_out_data, bcast_len,
        output busy, err_opcode, err_timeout
    );

    modport master (
        output i2c_rts, i2c_in_data, engine_in_rtr,
        input  i2c_rtr, engine_out_rts, bcast_out_data, bcast_len,
        input  busy, err_opcode, err_timeout
    );
endinterface

// File: rtl/cmd_assembler.sv
// Assembles an opcode byte plus payload bytes into a command and dispatches it to one engine.
// Optional inter-byte timeout in COLLECT is built only when CMD_TIMEOUT_EN is defined.
module cmd_assembler #(
    parameter int unsigned                 NUM_ENGINES    = 5,
    parameter int unsigned                 MAX_BYTES      = 16,
    parameter logic [NUM_ENGINES*8-1:0]    LEN_TABLE      = {8'd11, 8'd11, 8'd0, 8'd1, 8'd1},
    parameter int unsigned                 TIMEOUT_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           rst_,
    cmd_assembler_if.slave bus
);
    localparam int unsigned DW = MAX_BYTES * 8;
    localparam int unsigned CW = $clog2(MAX_BYTES + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DISPATCH} state_e;

    state_e                 state_q;
    logic                   rtr_q;
    logic                   busy_q;
    logic                   err_op_q;
    logic [NUM_ENGINES-1:0] sel_q;
    logic [NUM_ENGINES-1:0] rts_q;
    logic [DW-1:0]          data_q;
    logic [7:0]             len_q;
    logic [CW-1:0]          cnt_q;

    logic                   xfer_c;
    logic                   op_ok_c;
    logic                   last_c;
    logic                   ack_c;
    logic [NUM_ENGINES-1:0] op_hot_c;
    logic [7:0]             op_len_c;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    logic          err_tmo_q;
    logic          tmo_hit_c;
    assign tmo_hit_c       = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign bus.err_timeout = err_tmo_q;
`else
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
    end
    assign bus.err_timeout = 1'b0;
`endif

    // Opcode decode: one-hot engine select and payload length lookup.
    always_comb begin
        op_hot_c = '0;
        op_len_c = '0;
        for (int e = 0; e < NUM_ENGINES; e++) begin
            if (bus.i2c_in_data == 8'(e)) begin
                op_hot_c[e] = 1'b1;
                op_len_c    = LEN_TABLE[8*e +: 8];
            end
        end
    end

    assign xfer_c  = bus.i2c_rts & rtr_q;
    assign op_ok_c = (bus.i2c_in_data < 8'(NUM_ENGINES));
    assign last_c  = ((8'(cnt_q) + 8'd1) == len_q);
    // Only the selected engine's ready can complete a dispatch.
    assign ack_c   = |(bus.engine_in_rtr & rts_q);

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q  <= IDLE;
            rtr_q    <= 1'b1;
            busy_q   <= 1'b0;
            err_op_q <= 1'b0;
            sel_q    <= '0;
            rts_q    <= '0;
            data_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
`ifdef CMD_TIMEOUT_EN
            tmo_q     <= '0;
            err_tmo_q <= 1'b0;
`endif
        end else begin
            err_op_q <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            err_tmo_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
`ifdef CMD_TIMEOUT_EN
                    tmo_q <= '0;
`endif
                    if (xfer_c) begin
                        if (op_ok_c) begin
                            sel_q  <= op_hot_c;
                            data_q <= '0;
                            len_q  <= op_len_c;
                            cnt_q  <= '0;
                            busy_q <= 1'b1;
                            if (op_len_c == 8'd0) begin
                                state_q <= DISPATCH;
                                rts_q   <= op_hot_c;
                                rtr_q   <= 1'b0;
                            end else begin
                                state_q <= COLLECT;
                            end
                        end else begin
                            err_op_q <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (xfer_c) begin
                        for (int b = 0; b < MAX_BYTES; b++) begin
                            if (cnt_q == CW'(b)) data_q[8*b +: 8] <= bus.i2c_in_data;
                        end
                        cnt_q <= cnt_q + CW'(1);
`ifdef CMD_TIMEOUT_EN
                        tmo_q <= '0;
`endif
                        if (last_c) begin
                            state_q <= DISPATCH;
                            rts_q   <= sel_q;
                            rtr_q   <= 1'b0;
                        end
                    end
`ifdef CMD_TIMEOUT_EN
                    // Abort a stalled partial command.
                    else if (tmo_hit_c) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        err_tmo_q <= 1'b1;
                        tmo_q     <= '0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
`endif
                end
                DISPATCH: begin
                    if (ack_c) begin
                        state_q <= IDLE;
                        rts_q   <= '0;
                        rtr_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rts_q   <= '0;
                    rtr_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.i2c_rtr        = rtr_q;
    assign bus.busy           = busy_q;
    assign bus.err_opcode     = err_op_q;
    assign bus.engine_out_rts = rts_q;
    assign bus.bcast_out_data = data_q;
    assign bus.bcast_len      = len_q;
endmodule

// File: tb/tb_cmd_assembler.sv
// Scoreboard bench for cmd_assembler: expected dispatches queued at stimulus time, popped at dispatch.
module tb_cmd_assembler;
    localparam int unsigned NE = 5;
    localparam int unsigned MB = 16;

    typedef struct {
        logic [NE-1:0]   rts;
        logic [MB*8-1:0] data;
        logic [7:0]      len;
    } exp_t;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [MB*8-1:0] last_data;

    always #5 clk = ~clk;

    cmd_assembler_if #(.NUM_ENGINES(NE), .MAX_BYTES(MB)) bus ();

    cmd_assembler #(
        .NUM_ENGINES(NE), .MAX_BYTES(MB),
        .LEN_TABLE({8'd11, 8'd11, 8'd0, 8'd1, 8'd1}),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_(rst_), .bus(bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte and hold it until it transfers (bounded).
    task automatic drive_byte(input logic [7:0] b);
        int n = 0;
        bus.i2c_rts     = 1'b1;
        bus.i2c_in_data = b;
        while (!bus.i2c_rtr && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (bus.i2c_rtr !== 1'b1) begin
            errors++;
            $display("FAIL byte_accept: rtr=%b required 1 within 100 cycles", bus.i2c_rtr);
        end
        tick();
        bus.i2c_rts = 1'b0;
    endtask

    task automatic push_exp(input logic [NE-1:0] r, input logic [MB*8-1:0] d, input logic [7:0] l);
        exp_t e;
        e.rts = r; e.data = d; e.len = l;
        exp_q.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: size=0 required >0");
            e.rts = '0; e.data = '0; e.len = '0;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        tick(); tick();
        rst_ = 1'b1;
        checks += 6;
        if (bus.engine_out_rts !== '0) begin errors++; $display("FAIL reset_rts: got %b required 0", bus.engine_out_rts); end
        if (bus.bcast_out_data !== '0) begin errors++; $display("FAIL reset_data: got %h required 0", bus.bcast_out_data); end
        if (bus.bcast_len !== 8'd0) begin errors++; $display("FAIL reset_len: got %0d required 0", bus.bcast_len); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
        if (bus.err_opcode !== 1'b0 || bus.err_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b%b required 00", bus.err_opcode, bus.err_timeout);
        end
        if (bus.i2c_rtr !== 1'b1) begin errors++; $display("FAIL reset_rtr: got %b required 1", bus.i2c_rtr); end
    endtask

    task automatic test_long_cmd();
        logic [MB*8-1:0] d = '0;
        exp_t e;
        for (int k = 0; k < 11; k++) d[8*k +: 8] = 8'(k + 1);
        push_exp(5'b10000, d, 8'd11);
        drive_byte(8'd4);
        for (int k = 0; k < 11; k++) drive_byte(8'(k + 1));
        pop_exp(e);
        checks += 5;
        if (bus.engine_out_rts !== e.rts) begin errors++; $display("FAIL long_rts: got %b required %b", bus.engine_out_rts, e.rts); end
        if (bus.bcast_out_data !== e.data) begin errors++; $display("FAIL long_data: got %h required %h", bus.bcast_out_data, e.data); end
        if (bus.bcast_len !== e.len) begin errors++; $display("FAIL long_len: got %0d required %0d", bus.bcast_len, e.len); end
        if (bus.i2c_rtr !== 1'b0) begin errors++; $display("FAIL long_rtr: got %b required 0", bus.i2c_rtr); end
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL long_busy: got %b required 1", bus.busy); end
        bus.engine_in_rtr = 5'b01111;
        tick();
        checks++;
        if (bus.engine_out_rts !== e.rts) begin errors++; $display("FAIL long_other_rtr: got %b required %b", bus.engine_out_rts, e.rts); end
        bus.engine_in_rtr = 5'b10000;
        tick();
        bus.engine_in_rtr = '0;
        checks += 3;
        if (bus.engine_out_rts !== '0) begin errors++; $display("FAIL long_release_rts: got %b required 0", bus.engine_out_rts); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL long_release_busy: got %b required 0", bus.busy); end
        if (bus.i2c_rtr !== 1'b1) begin errors++; $display("FAIL long_release_rtr: got %b required 1", bus.i2c_rtr); end
        last_data = d;
    endtask

    task automatic test_bad_opcode();
        exp_t e;
        logic [MB*8-1:0] d = '0;
        drive_byte(8'd7);
        checks += 3;
        if (bus.err_opcode !== 1'b1) begin errors++; $display("FAIL badop_pulse: got %b required 1", bus.err_opcode); end
        if (bus.engine_out_rts !== '0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL badop_idle: rts=%b busy=%b required 0/0", bus.engine_out_rts, bus.busy);
        end
        if (bus.bcast_out_data !== last_data) begin errors++; $display("FAIL badop_data_hold: got %h required %h", bus.bcast_out_data, last_data); end
        tick();
        checks++;
        if (bus.err_opcode !== 1'b0) begin errors++; $display("FAIL badop_single: got %b required 0", bus.err_opcode); end
        d[7:0] = 8'hA5;
        push_exp(5'b00001, d, 8'd1);
        drive_byte(8'd0);
        drive_byte(8'hA5);
        pop_exp(e);
        checks += 3;
        if (bus.engine_out_rts !== e.rts) begin errors++; $display("FAIL op0_rts: got %b required %b", bus.engine_out_rts, e.rts); end
        if (bus.bcast_out_data !== e.data) begin errors++; $display("FAIL op0_data: got %h required %h", bus.bcast_out_data, e.data); end
        if (bus.bcast_len !== e.len) begin errors++; $display("FAIL op0_len: got %0d required %0d", bus.bcast_len, e.len); end
        bus.engine_in_rtr = 5'b00001;
        tick();
        bus.engine_in_rtr = '0;
        checks++;
        if (bus.engine_out_rts !== '0) begin errors++; $display("FAIL op0_release: got %b required 0", bus.engine_out_rts); end
    endtask

    task automatic test_zero_len_hold();
        exp_t e;
        int bad = 0;
        push_exp(5'b00100, '0, 8'd0);
        drive_byte(8'd2);
        pop_exp(e);
        checks += 3;
        if (bus.engine_out_rts !== e.rts) begin errors++; $display("FAIL zl_rts: got %b required %b", bus.engine_out_rts, e.rts); end
        if (bus.bcast_out_data !== e.data) begin errors++; $display("FAIL zl_data: got %h required %h", bus.bcast_out_data, e.data); end
        if (bus.bcast_len !== e.len) begin errors++; $display("FAIL zl_len: got %0d required %0d", bus.bcast_len, e.len); end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.engine_out_rts !== e.rts || bus.i2c_rtr !== 1'b0 ||
                bus.bcast_out_data !== e.data || bus.bcast_len !== e.len) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL zl_hold: unstable cycles=%0d required 0", bad); end
        bus.engine_in_rtr = 5'b00100;
        tick();
        bus.engine_in_rtr = '0;
        checks += 2;
        if (bus.engine_out_rts !== '0) begin errors++; $display("FAIL zl_release_rts: got %b required 0", bus.engine_out_rts); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL zl_release_busy: got %b required 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [MB*8-1:0] d = '0;
        int seen = 0;
        drive_byte(8'd3);
        for (int k = 0; k < 5; k++) drive_byte(8'(8'h10 + k));
        rst_ = 1'b0;
        tick();
        rst_ = 1'b1;
        checks += 3;
        if (bus.engine_out_rts !== '0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_ctrl: rts=%b busy=%b required 0/0", bus.engine_out_rts, bus.busy);
        end
        if (bus.bcast_out_data !== '0 || bus.bcast_len !== 8'd0) begin
            errors++; $display("FAIL rstmid_data: data=%h len=%0d required 0/0", bus.bcast_out_data, bus.bcast_len);
        end
        if (bus.i2c_rtr !== 1'b1) begin errors++; $display("FAIL rstmid_rtr: got %b required 1", bus.i2c_rtr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.engine_out_rts !== '0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rstmid_no_rts: rts cycles=%0d required 0", seen); end
        d[7:0] = 8'h3C;
        push_exp(5'b00010, d, 8'd1);
        drive_byte(8'd1);
        drive_byte(8'h3C);
        pop_exp(e);
        checks += 2;
        if (bus.engine_out_rts !== e.rts) begin errors++; $display("FAIL op1_rts: got %b required %b", bus.engine_out_rts, e.rts); end
        if (bus.bcast_out_data !== e.data) begin errors++; $display("FAIL op1_data: got %h required %h", bus.bcast_out_data, e.data); end
        bus.engine_in_rtr = 5'b00010;
        tick();
        bus.engine_in_rtr = '0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [MB*8-1:0] d0 = '0;
        logic [MB*8-1:0] d1 = '0;
        d0[7:0] = 8'h11;
        d1[7:0] = 8'h22;
        push_exp(5'b00001, d0, 8'd1);
        push_exp(5'b00010, d1, 8'd1);
        bus.engine_in_rtr = '1;
        drive_byte(8'd0);
        drive_byte(8'h11);
        pop_exp(e);
        checks += 2;
        if (bus.engine_out_rts !== e.rts) begin errors++; $display("FAIL b2b0_rts: got %b required %b", bus.engine_out_rts, e.rts); end
        if (bus.bcast_out_data !== e.data) begin errors++; $display("FAIL b2b0_data: got %h required %h", bus.bcast_out_data, e.data); end
        tick();
        checks += 2;
        if (bus.i2c_rtr !== 1'b1) begin errors++; $display("FAIL b2b_rtr_return: got %b required 1", bus.i2c_rtr); end
        if (bus.engine_out_rts !== '0) begin errors++; $display("FAIL b2b_gap_rts: got %b required 0", bus.engine_out_rts); end
        drive_byte(8'd1);
        drive_byte(8'h22);
        pop_exp(e);
        checks += 2;
        if (bus.engine_out_rts !== e.rts) begin errors++; $display("FAIL b2b1_rts: got %b required %b", bus.engine_out_rts, e.rts); end
        if (bus.bcast_out_data !== e.data) begin errors++; $display("FAIL b2b1_data: got %h required %h", bus.bcast_out_data, e.data); end
        tick();
        bus.engine_in_rtr = '0;
        checks++;
        if (bus.engine_out_rts !== '0) begin errors++; $display("FAIL b2b1_release: got %b required 0", bus.engine_out_rts); end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int first = -1;
        int rts_seen = 0;
        int busy_lo = 0;
        drive_byte(8'd4);
        drive_byte(8'h01);
        drive_byte(8'h02);
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (bus.err_timeout === 1'b1) begin
                pulses++;
                if (first < 0) first = n;
            end
            if (bus.engine_out_rts !== '0) rts_seen++;
            if (bus.busy !== 1'b1) busy_lo++;
        end
        checks += 2;
        if (rts_seen != 0) begin errors++; $display("FAIL tmo_no_rts: rts cycles=%0d required 0", rts_seen); end
`ifdef CMD_TIMEOUT_EN
        if (pulses != 1 || first != 8) begin
            errors++; $display("FAIL tmo_pulse: pulses=%0d at cycle %0d required 1 at cycle 8", pulses, first);
        end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL tmo_idle: busy=%b required 0", bus.busy); end
`else
        if (pulses != 0) begin errors++; $display("FAIL tmo_none: pulses=%0d required 0", pulses); end
        checks++;
        if (busy_lo != 0) begin errors++; $display("FAIL tmo_busy: busy-low cycles=%0d required 0", busy_lo); end
`endif
        rst_ = 1'b0;
        tick();
        rst_ = 1'b1;
    endtask

    initial begin
        bus.i2c_rts       = 1'b0;
        bus.i2c_in_data   = '0;
        bus.engine_in_rtr = '0;
        last_data         = '0;
        test_reset();
        test_long_cmd();
        test_bad_opcode();
        test_zero_len_hold();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: size=%0d required 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cmd_assembler.md
CMD_ASSEMBLER -- requirements
Module: cmd_assembler

Interface
REQ-001 SHALL have parameter NUM_ENGINES, default 5: number of engine channels and valid opcodes (0..NUM_ENGINES-1).
REQ-002 SHALL have parameter MAX_BYTES, default 16: maximum payload bytes per command.
REQ-003 SHALL have parameter LEN_TABLE, width NUM_ENGINES*8, default {8'd11,8'd11,8'd0,8'd1,8'd1}: byte field i is the payload length for opcode i; every entry SHALL be within 0..MAX_BYTES.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024: inter-byte timeout limit, used only when CMD_TIMEOUT_EN is defined.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst_  in  1  reset, synchronous, active-low.
REQ-007 i2c_rts  in  1  input byte valid.
REQ-008 i2c_rtr  out  1  block can accept a byte.
REQ-009 i2c_in_data  in  8  byte stream: opcode byte followed by payload bytes.
REQ-010 engine_out_rts  out  NUM_ENGINES  one-hot command-ready per engine.
REQ-011 engine_in_rtr  in  NUM_ENGINES  per-engine ready.
REQ-012 bcast_out_data  out  MAX_BYTES*8  assembled payload, shared by all engines.
REQ-013 bcast_len  out  8  payload byte count of the current command.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 err_opcode  out  1  one-cycle pulse when an opcode is rejected.
REQ-016 err_timeout  out  1  one-cycle pulse when a partial command is aborted.

Function
REQ-017 A byte transfer SHALL occur on a cycle where i2c_rts and i2c_rtr are both 1; i2c_rtr SHALL be 1 in IDLE and COLLECT and 0 in DISPATCH.
REQ-018 State machine SHALL have states IDLE, COLLECT and DISPATCH.
REQ-019 IDLE: a transferred byte is the opcode; if opcode < NUM_ENGINES, SHALL latch it, clear bcast_out_data to 0, load bcast_len from LEN_TABLE, zero the byte counter, and go to COLLECT (length > 0) or DISPATCH (length 0).
REQ-020 IDLE: opcode >= NUM_ENGINES SHALL pulse err_opcode on the next cycle and stay in IDLE; the byte is consumed.
REQ-021 COLLECT: payload byte k (0-based) SHALL be written to bcast_out_data[8k+7:8k] and the counter incremented; the transfer of byte bcast_len-1 SHALL move to DISPATCH.
REQ-022 DISPATCH: engine_out_rts SHALL drive bit[opcode] to 1 from the cycle after the final byte (or after the opcode for length 0); all other bits SHALL be 0.
REQ-023 engine_out_rts[opcode] SHALL hold until a cycle where engine_in_rtr[opcode] is 1; in the following cycle it SHALL be 0 and the state SHALL be IDLE.
REQ-024 bcast_out_data, bcast_len and engine_out_rts SHALL be stable for the whole of DISPATCH; bcast_out_data SHALL hold its last value in IDLE until the next valid opcode.
REQ-025 engine_in_rtr bits other than engine_in_rtr[opcode] SHALL be ignored; engine_in_rtr SHALL be ignored outside DISPATCH.
REQ-026 The byte counter SHALL be wide enough to reach MAX_BYTES without wrap-around; no write SHALL occur beyond byte MAX_BYTES-1.
REQ-027 Back-to-back: i2c_rtr SHALL return to 1 on the first IDLE cycle after handshake, so a new opcode can be accepted that same cycle.

Reset
REQ-028 With rst_ = 0 at a rising edge: state becomes IDLE, counter 0, bcast_out_data 0, bcast_len 0, engine_out_rts 0, err_opcode 0, err_timeout 0, timeout counter 0.
REQ-029 Reset mid-COLLECT or mid-DISPATCH SHALL drop the command with no engine_out_rts pulse; i2c_rtr SHALL be 1 on the first cycle after reset release.

Configuration
REQ-030 Macro CMD_TIMEOUT_EN defined: in COLLECT, a counter SHALL increment each cycle without a transfer and clear on a transfer; when it reaches TIMEOUT_CYCLES the block SHALL discard the command, pulse err_timeout for one cycle, and return to IDLE.
REQ-031 Macro CMD_TIMEOUT_EN undefined: COLLECT SHALL wait indefinitely, err_timeout SHALL be tied to 0, and no timeout counter SHALL be built.

Verification
REQ-032 Opcode 4 then bytes 0x01..0x0B -> engine_out_rts = 5'b10000 the cycle after 0x0B; bcast_out_data[87:0] = 0x0B0A..01; bcast_len = 11; upper bytes 0.
REQ-033 Opcode 2 (length 0) -> engine_out_rts = 5'b00100 on the next cycle; hold engine_in_rtr[2] = 0 for 10 cycles -> rts held, i2c_rtr = 0, data stable; assert rtr -> rts 0 and IDLE.
REQ-034 Opcode 7 -> err_opcode pulses once and engine_out_rts stays 0; then opcode 0 with byte 0xA5 -> engine_out_rts = 5'b00001 and bcast_out_data[7:0] = 0xA5.
REQ-035 Opcode 3 then 5 bytes, then rst_ low for 1 cycle -> all outputs 0; opcode 1 with 0x3C then completes normally on engine 1.
REQ-036 With CMD_TIMEOUT_EN and TIMEOUT_CYCLES = 8: opcode 4 plus 2 bytes, then idle -> err_timeout pulses 8 cycles after the last byte with no rts; without the macro, no pulse and busy stays 1.
